// File: rtl/buzzer_tone_generator.sv
// Square-wave buzzer driver. A tone request gates a fixed-frequency output,
// held for a minimum on-time and always ended after a complete high level.
module buzzer_tone_generator #(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int TONE_HZ       = 2_000,
  parameter int MIN_ON_CYCLES = 50_000
) (
  input  logic clk,
  input  logic rst,
  input  logic ctrl_en,
  input  logic ctrl_buzz,
  output logic buzzer_out,
  output logic active
);

  localparam int HALF_RAW    = CLK_FREQ_HZ / (2 * TONE_HZ);
  localparam int HALF_PERIOD = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int PH_W        = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int ON_W        = (MIN_ON_CYCLES > 0) ? $clog2(MIN_ON_CYCLES + 1) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_PERIOD - 1);
  localparam logic [ON_W-1:0] ON_MAX  = ON_W'(MIN_ON_CYCLES);

  typedef enum logic [1:0] {IDLE, TONE, FINISH} state_t;

  state_t          state, state_next;
  logic [PH_W-1:0] phase_cnt, phase_next;
  logic [ON_W-1:0] on_cnt, on_next;
  logic            out_next;
  logic            request, wrap, min_done;

  function automatic logic [ON_W-1:0] sat_inc(input logic [ON_W-1:0] v);
    return (v >= ON_MAX) ? ON_MAX : v + ON_W'(1);
  endfunction

  assign request  = ctrl_en & ctrl_buzz;
  assign wrap     = (phase_cnt == PH_LAST);
  assign min_done = (on_cnt == ON_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      phase_cnt  <= '0;
      on_cnt     <= '0;
      buzzer_out <= 1'b0;
      active     <= 1'b0;
    end else begin
      state      <= state_next;
      phase_cnt  <= phase_next;
      on_cnt     <= on_next;
      buzzer_out <= out_next;
      active     <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (request) state_next = TONE;
      TONE: begin
        if (!ctrl_en)
          state_next = IDLE;
        // A high level that is about to wrap is already complete, so stop directly.
        else if (!request && min_done)
          state_next = (buzzer_out && !wrap) ? FINISH : IDLE;
      end
      FINISH: begin
        if (!ctrl_en)     state_next = IDLE;
        else if (request) state_next = TONE;
        else if (wrap)    state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    phase_next = '0;
    on_next    = '0;
    out_next   = 1'b0;
    if (state_next == IDLE) begin
      phase_next = '0;
      on_next    = '0;
      out_next   = 1'b0;
    end else if (state == IDLE) begin
      out_next = 1'b1;
    end else begin
      // Phase runs uninterrupted across TONE/FINISH so re-requests never glitch the period.
      phase_next = wrap ? '0 : phase_cnt + PH_W'(1);
      out_next   = wrap ? ~buzzer_out : buzzer_out;
      if (state == TONE && state_next == TONE)
        on_next = sat_inc(on_cnt);
      else if (state == FINISH && state_next == TONE)
        on_next = '0;
      else
        on_next = on_cnt;
    end
  end

endmodule

// File: tb/tb_buzzer_tone_generator.sv
// Directed bench for buzzer_tone_generator with a 5-cycle half-period and
// a 20-cycle minimum on-time.
module tb_buzzer_tone_generator;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ctrl_en = 1'b0;
  logic ctrl_buzz = 1'b0;
  logic buzzer_out;
  logic active;

  int vectors = 0;
  int miscompares = 0;

  buzzer_tone_generator #(
    .CLK_FREQ_HZ(1000),
    .TONE_HZ(100),
    .MIN_ON_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ctrl_en(ctrl_en),
    .ctrl_buzz(ctrl_buzz),
    .buzzer_out(buzzer_out),
    .active(active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs == exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic bz);
    ctrl_en   = en;
    ctrl_buzz = bz;
    @(posedge clk);
    #1;
  endtask

  function automatic logic tone_level(input int k);
    return ((k / 5) % 2) == 0;
  endfunction

  initial begin
    // Held in reset while a request is present
    step(1'b1, 1'b1);
    check("rst_out", buzzer_out, 1'b0);
    check("rst_act", active, 1'b0);
    step(1'b1, 1'b1);
    check("rst_out2", buzzer_out, 1'b0);
    check("rst_act2", active, 1'b0);
    rst = 1'b1;

    // Release: first edge drives high, then toggles every 5 cycles
    for (int k = 0; k < 15; k++) begin
      step(1'b1, 1'b1);
      check($sformatf("rel_out%0d", k), buzzer_out, tone_level(k));
      check($sformatf("rel_act%0d", k), active, 1'b1);
    end
    step(1'b0, 1'b1);
    check("rel_mute_out", buzzer_out, 1'b0);
    check("rel_mute_act", active, 1'b0);

    // Single-cycle pulse stretched to a full minimum tone
    step(1'b1, 1'b1);
    check("pul_out0", buzzer_out, 1'b1);
    check("pul_act0", active, 1'b1);
    for (int k = 1; k < 30; k++) begin
      step(1'b1, 1'b0);
      check($sformatf("pul_out%0d", k), buzzer_out, (k < 25) ? tone_level(k) : 1'b0);
      check($sformatf("pul_act%0d", k), active, (k < 25) ? 1'b1 : 1'b0);
    end

    // Enable dropped while output is low
    for (int k = 0; k < 7; k++) step(1'b1, 1'b1);
    check("mlo_pre_out", buzzer_out, 1'b0);
    check("mlo_pre_act", active, 1'b1);
    step(1'b0, 1'b1);
    check("mlo_out", buzzer_out, 1'b0);
    check("mlo_act", active, 1'b0);
    step(1'b0, 1'b0);
    check("mlo_idle_act", active, 1'b0);

    // Enable dropped while output is high
    for (int k = 0; k < 12; k++) step(1'b1, 1'b1);
    check("mhi_pre_out", buzzer_out, 1'b1);
    check("mhi_pre_act", active, 1'b1);
    step(1'b0, 1'b1);
    check("mhi_out", buzzer_out, 1'b0);
    check("mhi_act", active, 1'b0);

    // Release while high, re-request during FINISH: waveform undisturbed
    for (int k = 0; k < 56; k++) begin
      step(1'b1, (k == 31 || k == 32) ? 1'b0 : 1'b1);
      check($sformatf("fin_out%0d", k), buzzer_out, tone_level(k));
      check($sformatf("fin_act%0d", k), active, 1'b1);
    end
    step(1'b0, 1'b0);
    check("fin_end_out", buzzer_out, 1'b0);
    check("fin_end_act", active, 1'b0);

    // Request with enable low never sounds
    for (int k = 0; k < 100; k++) begin
      step(1'b0, 1'b1);
      check($sformatf("dis_out%0d", k), buzzer_out, 1'b0);
      check($sformatf("dis_act%0d", k), active, 1'b0);
    end

    // Asynchronous reset mid-cycle with output high
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1);
    check("arst_pre_out", buzzer_out, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("arst_out", buzzer_out, 1'b0);
    check("arst_act", active, 1'b0);
    check_int("arst_phase", int'(dut.phase_cnt), 0);
    check_int("arst_on", int'(dut.on_cnt), 0);
    step(1'b1, 1'b1);
    check("arst_hold_out", buzzer_out, 1'b0);
    #2 rst = 1'b1;
    step(1'b1, 1'b1);
    check("arst_rel_out", buzzer_out, 1'b1);
    check("arst_rel_act", active, 1'b1);
    check_int("arst_rel_phase", int'(dut.phase_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
